// File: rtl/rv_fetch_resp.sv
// Instruction fetch responder: one outstanding memory read feeding a two-entry in-order buffer.
// Optional error tagging is enabled with the FETCH_RESP_ERR_EN macro.
module rv_fetch_resp #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_req,
   input  logic [31:2] i_pc,
   output logic        o_ready,
   input  logic        i_flush,
   input  logic        i_stall,
   output logic        o_mem_rd,
   output logic [31:2] o_mem_addr,
   input  logic        i_mem_ack,
   input  logic [31:0] i_mem_rdata,
`ifdef FETCH_RESP_ERR_EN
   input  logic        i_mem_err,
   output logic        o_err,
`endif
   output logic        o_valid,
   output logic [31:0] o_instr,
   output logic [31:2] o_pc
);

`ifdef FETCH_RESP_ERR_EN
   localparam int EW = 63;
`else
   localparam int EW = 62;
`endif

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Empty slots always hold the idle pattern so the head drives NOP/0 directly.
   localparam logic [EW-1:0] EMPTY_ENT = {{(EW-32){1'b0}}, NOP_INSTR};

   state_t          state_r;
   logic            mem_rd_r;
   logic [31:2]     mem_addr_r;
   logic [1:0]      count_r;
   logic [EW-1:0]   ent0_r;
   logic [EW-1:0]   ent1_r;

   logic            accept_s;
   logic            push_s;
   logic            pop_s;
   logic [EW-1:0]   new_ent_s;
   logic [EW-1:0]   ent0_n_s;
   logic [EW-1:0]   ent1_n_s;
   logic [1:0]      count_n_s;

   assign o_ready  = (state_r == ST_IDLE) && (count_r < 2'd2) && !i_flush;
   assign accept_s = i_req && o_ready;
   assign push_s   = (state_r == ST_BUSY) && i_mem_ack && !i_flush;
   assign pop_s    = (count_r != 2'd0) && !i_stall;

`ifdef FETCH_RESP_ERR_EN
   assign new_ent_s = {i_mem_err, mem_addr_r, (i_mem_err ? NOP_INSTR : i_mem_rdata)};
   assign o_err     = ent0_r[62];
`else
   assign new_ent_s = {mem_addr_r, i_mem_rdata};
`endif

   assign o_mem_rd   = mem_rd_r;
   assign o_mem_addr = mem_addr_r;
   assign o_valid    = (count_r != 2'd0);
   assign o_instr    = ent0_r[31:0];
   assign o_pc       = ent0_r[61:32];

   // Next buffer contents: flush wins, otherwise push/pop with in-order shift.
   always_comb begin
      ent0_n_s  = ent0_r;
      ent1_n_s  = ent1_r;
      count_n_s = count_r;
      if (i_flush) begin
         ent0_n_s  = EMPTY_ENT;
         ent1_n_s  = EMPTY_ENT;
         count_n_s = 2'd0;
      end else begin
         case ({push_s, pop_s})
            2'b10: begin
               if (count_r == 2'd0) begin
                  ent0_n_s = new_ent_s;
               end else begin
                  ent1_n_s = new_ent_s;
               end
               count_n_s = count_r + 2'd1;
            end
            2'b01: begin
               ent0_n_s  = ent1_r;
               ent1_n_s  = EMPTY_ENT;
               count_n_s = count_r - 2'd1;
            end
            2'b11: begin
               if (count_r == 2'd1) begin
                  ent0_n_s = new_ent_s;
               end else begin
                  ent0_n_s = ent1_r;
                  ent1_n_s = new_ent_s;
               end
            end
            default: begin
               count_n_s = count_r;
            end
         endcase
      end
   end

   // Output buffer registers.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         ent0_r  <= EMPTY_ENT;
         ent1_r  <= EMPTY_ENT;
         count_r <= 2'd0;
      end else begin
         ent0_r  <= ent0_n_s;
         ent1_r  <= ent1_n_s;
         count_r <= count_n_s;
      end
   end

   // Memory access FSM; DRAIN waits out a flushed read so the bus handshake completes.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_r    <= ST_IDLE;
         mem_rd_r   <= 1'b0;
         mem_addr_r <= 30'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  mem_addr_r <= i_pc;
                  mem_rd_r   <= 1'b1;
                  state_r    <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (i_mem_ack) begin
                  mem_rd_r <= 1'b0;
                  state_r  <= ST_IDLE;
               end else if (i_flush) begin
                  state_r <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (i_mem_ack) begin
                  mem_rd_r <= 1'b0;
                  state_r  <= ST_IDLE;
               end
            end
            default: begin
               mem_rd_r <= 1'b0;
               state_r  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/rv_fetch_resp.md
RV_FETCH_RESP -- requirements
Module: rv_fetch_resp

Interface
REQ-001 Parameter NOP_INSTR, default 32'h0000_0013, instruction word driven on o_instr whenever o_valid is 0.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_reset_n  input  1  asynchronous active-low reset.
REQ-004 i_req  input  1  fetch request valid from PC generator.
REQ-005 i_pc  input  [31:2]  word address of requested instruction.
REQ-006 o_ready  output  1  request accepted this cycle when i_req && o_ready.
REQ-007 i_flush  input  1  redirect; discard all buffered and in-flight fetches.
REQ-008 i_stall  input  1  consumer not taking head entry.
REQ-009 o_mem_rd  output  1  memory read strobe, held until acknowledged.
REQ-010 o_mem_addr  output  [31:2]  memory word address, stable while o_mem_rd.
REQ-011 i_mem_ack  input  1  read complete; i_mem_rdata valid this cycle.
REQ-012 i_mem_rdata  input  [31:0]  read data.
REQ-013 o_valid  output  1  head buffer entry valid.
REQ-014 o_instr  output  [31:0]  head entry instruction.
REQ-015 o_pc  output  [31:2]  head entry word address.

Function
REQ-016 Two-entry in-order output buffer {pc, instr}, occupancy count 0..2; o_valid = (count != 0).
REQ-017 FSM states IDLE, BUSY, DRAIN; o_ready = (state == IDLE) && (count < 2) && !i_flush, combinational.
REQ-018 IDLE: accepted request registers i_pc into o_mem_addr, sets o_mem_rd, enters BUSY at next edge.
REQ-019 BUSY: o_mem_rd = 1; i_mem_ack without i_flush pushes {o_mem_addr, i_mem_rdata}, clears o_mem_rd, returns to IDLE.
REQ-020 Minimum latency: request accepted cycle N, o_mem_rd from N+1, ack at N+1 gives o_valid at N+2.
REQ-021 One outstanding memory read at most; o_ready is 0 in BUSY and DRAIN.
REQ-022 Pop when o_valid && !i_stall; push and pop in same cycle leave count unchanged; entries shift in order.
REQ-023 Accept only with count < 2 guarantees a free slot at ack; no push may be lost or overwrite.
REQ-024 i_flush has priority over push, pop and accept: count cleared to 0, o_valid 0 next cycle.
REQ-025 i_flush in BUSY without ack: enter DRAIN, keep o_mem_rd/o_mem_addr until ack, discard data, then IDLE.
REQ-026 i_flush in BUSY coincident with ack: discard data, clear o_mem_rd, enter IDLE.
REQ-027 i_flush in DRAIN or IDLE: buffer cleared, state unchanged except DRAIN still awaits ack.
REQ-028 o_instr = NOP_INSTR and o_pc = 0 while count == 0.
REQ-029 i_mem_ack outside BUSY/DRAIN ignored.

Reset
REQ-030 i_reset_n low asynchronously forces state IDLE, count 0, o_mem_rd 0, o_mem_addr 0, o_valid 0, o_instr NOP_INSTR, o_pc 0.
REQ-031 Reset mid-access abandons read; responder state after release is IDLE with empty buffer.

Configuration
REQ-032 Macro FETCH_RESP_ERR_EN defined: adds input i_mem_err (1, qualified by i_mem_ack) and output o_err (1, head entry error flag); error entry stores instr NOP_INSTR, o_err = 1 when that entry is head.
REQ-033 FETCH_RESP_ERR_EN undefined: neither port exists, all entries error-free; all other behaviour identical.

Verification
REQ-034 Reset, i_req=1 pc=0x40>>2 at N, ack at N+1 rdata=32'h00500093 -> o_valid at N+2, o_pc=0x10, o_instr=32'h00500093.
REQ-035 i_stall=1, two fetches 0x10, 0x11 acked -> count 2, o_ready=0; release stall -> 0x10 then 0x11 on consecutive cycles, then o_instr=32'h0000_0013.
REQ-036 Accept pc 0x20, hold ack 3 cycles, i_flush 1 cycle later -> DRAIN, o_mem_rd held until ack, data dropped, o_valid never 1, IDLE after ack.
REQ-037 Flush coincident with ack and one buffered entry -> o_valid 0 next cycle, count 0, next request accepted.
REQ-038 Assert i_reset_n=0 asynchronously mid-BUSY with count 1 -> o_mem_rd, o_valid drop before next edge; post-reset fetch returns correct data.
REQ-039 With FETCH_RESP_ERR_EN, ack with i_mem_err=1 at pc 0x30 -> o_valid=1, o_err=1, o_instr=NOP_INSTR.
